// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Instruction-cycle controller for the 8-bit CPU. It steps through a fixed
// 8-phase fetch/execute cycle. It decodes the opcode held in the instruction
// register, together with the accumulator zero flag, into per-phase control
// strobes for the PC, the address mux, memory, the IR and the accumulator.
//
// Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE,
//         4 OP_ADDR,   5 OP_FETCH,   6 ALU_OP,    7 STORE
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-low reset
//   step    in   single-step request (present only with CPU_SINGLE_STEP_EN)
//   opcode  in   OP_W-bit opcode from the IR (meaningful in phases 4-7)
//   zero    in   accumulator == 0
//   sel     out  address mux: 1 = PC, 0 = IR address
//   rd      out  memory read enable
//   ld_ir   out  instruction register load strobe
//   inc_pc  out  PC increment
//   ld_pc   out  PC load from the IR address field
//   ld_ac   out  accumulator load
//   wr      out  memory write strobe
//   data_e  out  accumulator drives the data bus
//   halt    out  processor halted (sticky until reset)
//
// Optional feature, macro CPU_SINGLE_STEP_EN:
//   Adds the step input and a WAIT state. The sequencer enters WAIT on reset
//   and after every phase 7. It leaves WAIT for phase 0 on the cycle after
//   step=1 is sampled.
//
// All outputs are a combinational decode of the state (phase, halted, wait)
// and the live opcode/zero inputs. There are no output registers.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CPU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            ld_ac,
  output logic            wr,
  output logic            data_e,
  output logic            halt
);

  if (OP_W != 3) begin : g_bad_op_w
    $error("cpu_sequencer: OP_W must be 3");
  end

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
`ifdef CPU_SINGLE_STEP_EN
  logic   wait_q, wait_d;
`endif

  logic is_aluop, is_skz, is_sto, is_jmp, is_hlt;

  always_comb begin
    is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    is_skz   = (opcode == OP_SKZ);
    is_sto   = (opcode == OP_STO);
    is_jmp   = (opcode == OP_JMP);
    is_hlt   = (opcode == OP_HLT);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    phase_d  = phase_q;
    halted_d = halted_q;
`ifdef CPU_SINGLE_STEP_EN
    wait_d   = wait_q;
`endif
    if (halted_q) begin
      // Frozen at OP_FETCH until reset.
      phase_d = phase_q;
    end
`ifdef CPU_SINGLE_STEP_EN
    else if (wait_q) begin
      if (step) begin
        wait_d  = 1'b0;
        phase_d = PH_INST_ADDR;
      end
    end
`endif
    else begin
      // HLT still lets the phase-4 PC increment happen, so the PC ends up
      // past the HLT. The halt takes effect as phase 5 begins.
      if (phase_q == PH_OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end
      if (phase_q == PH_STORE) begin
        phase_d = PH_INST_ADDR;
`ifdef CPU_SINGLE_STEP_EN
        wait_d  = 1'b1;
`endif
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register here is control state and is reset. There is no storage array
    // that could go without a reset.
    if (!rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
`ifdef CPU_SINGLE_STEP_EN
      wait_q   <= 1'b1;
`endif
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
`ifdef CPU_SINGLE_STEP_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = halted_q;
    if (halted_q) begin
      halt = 1'b1;
    end
`ifdef CPU_SINGLE_STEP_EN
    else if (wait_q) begin
      sel = 1'b1;
    end
`endif
    else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
        end
        PH_OP_FETCH: begin
          rd = is_aluop;
        end
        PH_ALU_OP: begin
          rd     = is_aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          // The PC gives load priority, so ld_pc and inc_pc together on JMP
          // is a plain jump.
          rd     = is_aluop;
          ld_ac  = is_aluop;
          ld_pc  = is_jmp;
          inc_pc = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;

`ifdef CPU_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  localparam int INSTR_CYC = 9;
`else
  localparam bit STEP_MODE = 1'b0;
  localparam int INSTR_CYC = 8;
`endif

  localparam logic [8:0] SEL_ONLY  = 9'b1_0000_0000;
  localparam logic [8:0] HALT_ONLY = 9'b0_0000_0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: instruction-cycle position as a plain integer.
  int m_phase  = 0;
  bit m_halted = 1'b0;
  bit m_wait   = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer #(.OP_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CPU_SINGLE_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  wire [8:0] dut_o = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}, taken
  // from the per-phase table of the instruction cycle.
  function automatic logic [8:0] exp_o();
    bit alu, s, r, li, ip, lp, la, w, de;
    if (m_halted) return HALT_ONLY;
    if (m_wait)   return SEL_ONLY;
    alu = (opcode >= 3'd2) && (opcode <= 3'd5);
    s   = (m_phase <= 3);
    r   = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu);
    li  = (m_phase == 2) || (m_phase == 3);
    ip  = (m_phase == 4) || (m_phase == 6 && opcode == 3'd1 && zero) ||
          (m_phase == 7 && opcode == 3'd7);
    lp  = (m_phase >= 6) && (opcode == 3'd7);
    la  = (m_phase == 7) && alu;
    w   = (m_phase == 7) && (opcode == 3'd6);
    de  = (m_phase >= 6) && (opcode == 3'd6);
    return {s, r, li, ip, lp, la, w, de, 1'b0};
  endfunction

  // Instruction opcode during execute phases, anything during fetch.
  function automatic logic [2:0] pick(input logic [2:0] instr);
    if (!m_wait && !m_halted && m_phase >= 4) return instr;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic drive(input logic r, input logic [2:0] op, input logic z,
                       input logic s);
    @(negedge clk);
    rst = r; opcode = op; zero = z; step = s;
    #1;
  endtask

  // Clock edge and model update from the inputs held across it.
  task automatic advance();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_phase = 0; m_halted = 1'b0; m_wait = STEP_MODE;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_wait) begin
      if (step) begin m_wait = 1'b0; m_phase = 0; end
    end else begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      if (m_phase == 7) begin m_phase = 0; m_wait = STEP_MODE; end
      else m_phase++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    int n_rd, n_ir, n_ac;
    n_rd = 0; n_ir = 0; n_ac = 0;
    drive(1'b0, 3'd2, 1'b0, 1'b0); advance();
    drive(1'b0, 3'd2, 1'b0, 1'b0);
    checks++;
    if (dut_o !== SEL_ONLY) begin
      errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, dut_o, SEL_ONLY);
    end
    advance();
    for (int i = 0; i <= INSTR_CYC; i++) begin
      drive(1'b1, 3'd2, 1'b0, 1'b1);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL reset_seq cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      if (i == 0 || i == INSTR_CYC) begin
        checks++;
        if (dut_o !== SEL_ONLY) begin
          errors++; $display("FAIL reset_wrap i=%0d got=%b exp=%b", i, dut_o, SEL_ONLY);
        end
      end
      if (i < INSTR_CYC) begin
        n_rd += int'(rd); n_ir += int'(ld_ir); n_ac += int'(ld_ac);
      end
      advance();
    end
    checks++;
    if (n_rd !== 6 || n_ir !== 2 || n_ac !== 1) begin
      errors++; $display("FAIL add_counts got rd=%0d ir=%0d ac=%0d exp 6 2 1", n_rd, n_ir, n_ac);
    end
  endtask

  task automatic test_sto();
    int n_wr, n_de, n_rd;
    n_wr = 0; n_de = 0; n_rd = 0;
    do_reset(1);
    for (int i = 0; i < INSTR_CYC; i++) begin
      drive(1'b1, pick(3'd6), 1'b0, 1'b1);
      checks++;
      if (dut_o !== exp_o() || (rd && wr)) begin
        errors++; $display("FAIL sto cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      n_wr += int'(wr); n_de += int'(data_e); n_rd += int'(rd);
      advance();
    end
    checks++;
    if (n_wr !== 1 || n_de !== 2 || n_rd !== 3) begin
      errors++; $display("FAIL sto_counts got wr=%0d de=%0d rd=%0d exp 1 2 3", n_wr, n_de, n_rd);
    end
  endtask

  task automatic test_skz();
    int n_inc;
    for (int z = 1; z >= 0; z--) begin
      n_inc = 0;
      do_reset(1);
      for (int i = 0; i < INSTR_CYC; i++) begin
        drive(1'b1, pick(3'd1), 1'(z), 1'b1);
        checks++;
        if (dut_o !== exp_o()) begin
          errors++; $display("FAIL skz cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
        end
        n_inc += int'(inc_pc);
        advance();
      end
      checks++;
      if (n_inc !== 1 + z) begin
        errors++; $display("FAIL skz_inc zero=%0d got=%0d exp=%0d", z, n_inc, 1 + z);
      end
    end
  endtask

  task automatic test_jmp();
    int n_lp, n_inc, n_both;
    n_lp = 0; n_inc = 0; n_both = 0;
    do_reset(1);
    for (int i = 0; i < INSTR_CYC; i++) begin
      drive(1'b1, pick(3'd7), 1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL jmp cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      n_lp += int'(ld_pc); n_inc += int'(inc_pc); n_both += int'(ld_pc && inc_pc);
      advance();
    end
    checks++;
    if (n_lp !== 2 || n_inc !== 2 || n_both !== 1) begin
      errors++; $display("FAIL jmp_counts got lp=%0d inc=%0d both=%0d exp 2 2 1", n_lp, n_inc, n_both);
    end
  endtask

  task automatic test_hlt();
    int n_inc;
    n_inc = 0;
    do_reset(1);
    for (int i = 0; i < INSTR_CYC - 3; i++) begin
      drive(1'b1, pick(3'd0), 1'b0, 1'b1);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL hlt_run cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      n_inc += int'(inc_pc);
      advance();
    end
    checks++;
    if (n_inc !== 1) begin
      errors++; $display("FAIL hlt_inc got=%0d exp=1", n_inc);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (dut_o !== HALT_ONLY) begin
        errors++; $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, dut_o, HALT_ONLY);
      end
      advance();
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0); advance();
    drive(1'b1, 3'd0, 1'b0, 1'b0);
    checks++;
    if (dut_o !== SEL_ONLY) begin
      errors++; $display("FAIL hlt_clear got=%b exp=%b", dut_o, SEL_ONLY);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    for (int i = 0; i < INSTR_CYC - 1; i++) begin
      drive(1'b1, pick(3'd6), 1'b0, 1'b1);
      advance();
    end
    drive(1'b0, 3'd6, 1'b0, 1'b1);
    checks++;
    if (wr !== 1'b1) begin
      errors++; $display("FAIL mid_wr_before got=%b exp=1", wr);
    end
    advance();
    drive(1'b1, 3'd6, 1'b0, !STEP_MODE);
    checks++;
    if (dut_o !== SEL_ONLY) begin
      errors++; $display("FAIL mid_reset got=%b exp=%b", dut_o, SEL_ONLY);
    end
    advance();
  endtask

`ifdef CPU_SINGLE_STEP_EN
  task automatic test_single_step();
    int n_ir;
    n_ir = 0;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      checks++;
      if (dut_o !== SEL_ONLY) begin
        errors++; $display("FAIL wait_hold cyc=%0d got=%b exp=%b", cyc, dut_o, SEL_ONLY);
      end
      advance();
    end
    drive(1'b1, 3'd2, 1'b0, 1'b1); advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, pick(3'd2), 1'b0, 1'b0);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL step_run cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      if (i >= 8) begin
        checks++;
        if (dut_o !== SEL_ONLY) begin
          errors++; $display("FAIL step_back i=%0d got=%b exp=%b", i, dut_o, SEL_ONLY);
        end
      end
      n_ir += int'(ld_ir);
      advance();
    end
    checks++;
    if (n_ir !== 2) begin
      errors++; $display("FAIL step_ir got=%0d exp=2", n_ir);
    end
  endtask
`endif

  task automatic test_random();
    logic r;
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 39) != 0) && !(m_halted && $urandom_range(0, 7) == 0);
      drive(r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      checks++;
      if (dut_o !== exp_o() || (rd && wr)) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_o, exp_o());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_mid_reset();
`ifdef CPU_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
